// File: rtl/pinmap_pkg.sv
// Shared types and default pin-map tables for pinmap_term_to_pin.
// Default kinds: BC547 (4 pins), 2N2905/2N3053 (3 pins), 2N2222 (3 pins, rotated ports).
package pinmap_pkg;

  localparam int NET_W_DEF = 16;
  localparam logic [NET_W_DEF-1:0] NET_NC = '1;

  typedef enum logic [1:0] {
    KIND_BC547  = 2'd0,
    KIND_2N2905 = 2'd1,
    KIND_2N2222 = 2'd2,
    KIND_2N3053 = 2'd3
  } kind_e;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DRAIN} state_e;

  function automatic int def_npins(input int kind);
    if (kind == int'(KIND_BC547)) return 4;
    if (kind <= int'(KIND_2N3053)) return 3;
    return 0;
  endfunction

  // Terminal index (0-based) feeding package pin 'pin' (1-based).
  function automatic int def_inv(input int kind, input int pin);
    if (pin < 1) return 0;
    if (kind == int'(KIND_2N2222)) begin
      case (pin)
        1:       return 1;
        2:       return 2;
        3:       return 0;
        default: return pin - 1;
      endcase
    end
    return pin - 1;
  endfunction

endpackage

// File: rtl/pinmap_term_buf.sv
// Terminal net-ID register file: one write port, one async read port,
// synchronous clear to the unconnected marker (all ones).
module pinmap_term_buf #(
  parameter int NET_W    = 16,
  parameter int MAX_PINS = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        we,
  input  logic [$clog2(MAX_PINS)-1:0] waddr,
  input  logic [NET_W-1:0]            wdata,
  input  logic [$clog2(MAX_PINS)-1:0] raddr,
  output logic [NET_W-1:0]            rdata
);

  logic [MAX_PINS-1:0][NET_W-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (clr)     mem_d = '1;
    else if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) mem_q <= '1;
    else     mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pinmap_term_to_pin.sv
// Re-orders one device's terminal net IDs into package-pin order (fill, then drain).
// Define PINMAP_PROG_EN to make the INV/NPINS tables writable through cfg_* ports.
module pinmap_term_to_pin
  import pinmap_pkg::*;
#(
  parameter int NET_W    = 16,
  parameter int MAX_PINS = 8,
  parameter int KIND_W   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [NET_W-1:0]              s_net,
  input  logic [KIND_W-1:0]             s_kind,
  input  logic                          s_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(MAX_PINS+1)-1:0] m_pin,
  output logic [NET_W-1:0]              m_net,
  output logic                          m_last,
  output logic                          err_len,
`ifdef PINMAP_PROG_EN
  input  logic                          cfg_we,
  input  logic [KIND_W-1:0]             cfg_kind,
  input  logic [$clog2(MAX_PINS+1)-1:0] cfg_idx,
  input  logic [$clog2(MAX_PINS)-1:0]   cfg_term,
  input  logic                          cfg_n_we,
`endif
  output logic                          busy
);

  localparam int PIN_W  = $clog2(MAX_PINS+1);
  localparam int TERM_W = $clog2(MAX_PINS);
  localparam int NKIND  = 2**KIND_W;

  logic [TERM_W-1:0] inv_tab   [NKIND][MAX_PINS+1];
  logic [PIN_W-1:0]  npins_tab [NKIND];

  state_e            state_q, state_d;
  logic [KIND_W-1:0] kind_q, kind_d;
  logic [PIN_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              s_ready_q, s_ready_d;
  logic              m_valid_q, m_valid_d;
  logic [PIN_W-1:0]  m_pin_q, m_pin_d;
  logic [NET_W-1:0]  m_net_q, m_net_d;
  logic              m_last_q, m_last_d;
  logic              err_len_q, err_len_d;

  assign busy = (state_q != ST_IDLE);

`ifdef PINMAP_PROG_EN
  logic [TERM_W-1:0] inv_q   [NKIND][MAX_PINS+1];
  logic [TERM_W-1:0] inv_d   [NKIND][MAX_PINS+1];
  logic [PIN_W-1:0]  npins_q [NKIND];
  logic [PIN_W-1:0]  npins_d [NKIND];

  always_comb begin
    inv_d   = inv_q;
    npins_d = npins_q;
    if (!busy && cfg_idx <= PIN_W'(MAX_PINS)) begin
      if (cfg_we)   inv_d[cfg_kind][cfg_idx] = cfg_term;
      if (cfg_n_we) npins_d[cfg_kind]        = cfg_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NKIND; k++) begin
        npins_q[k] <= PIN_W'(def_npins(k));
        for (int p = 0; p <= MAX_PINS; p++) inv_q[k][p] <= TERM_W'(def_inv(k, p));
      end
    end else begin
      inv_q   <= inv_d;
      npins_q <= npins_d;
    end
  end

  assign inv_tab   = inv_q;
  assign npins_tab = npins_q;
`else
  always_comb begin
    for (int k = 0; k < NKIND; k++) begin
      npins_tab[k] = PIN_W'(def_npins(k));
      for (int p = 0; p <= MAX_PINS; p++) inv_tab[k][p] = TERM_W'(def_inv(k, p));
    end
  end
`endif

  logic              acc, wr_ok, ovf_now, buf_clr;
  logic [KIND_W-1:0] kind_eff;
  logic [PIN_W-1:0]  rcv, rd_pin, npins_eff;
  logic [TERM_W-1:0] waddr, rd_term;
  logic [NET_W-1:0]  rd_net, rd_net_byp;

  assign acc       = s_valid & s_ready_q;
  assign kind_eff  = (state_q == ST_IDLE) ? s_kind : kind_q;
  assign wr_ok     = acc && (cnt_q < PIN_W'(MAX_PINS));
  assign waddr     = cnt_q[TERM_W-1:0];
  assign rcv       = wr_ok ? cnt_q + PIN_W'(1) : cnt_q;
  assign ovf_now   = ovf_q | (acc & ~wr_ok);
  assign npins_eff = npins_tab[kind_eff];
  // Entry reads pin 1 while the closing beat is still being written: bypass it.
  assign rd_pin     = (state_q == ST_DRAIN) ? m_pin_q + PIN_W'(1) : PIN_W'(1);
  assign rd_term    = (rd_pin <= PIN_W'(MAX_PINS)) ? inv_tab[kind_eff][rd_pin] : '0;
  assign rd_net_byp = (wr_ok && waddr == rd_term) ? s_net : rd_net;

  pinmap_term_buf #(.NET_W(NET_W), .MAX_PINS(MAX_PINS)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .clr   (buf_clr),
    .we    (wr_ok),
    .waddr (waddr),
    .wdata (s_net),
    .raddr (rd_term),
    .rdata (rd_net)
  );

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    s_ready_d = s_ready_q;
    m_valid_d = m_valid_q;
    m_pin_d   = m_pin_q;
    m_net_d   = m_net_q;
    m_last_d  = m_last_q;
    err_len_d = 1'b0;
    buf_clr   = 1'b0;
    case (state_q)
      ST_IDLE, ST_FILL: begin
        if (acc) begin
          kind_d  = kind_eff;
          cnt_d   = rcv;
          ovf_d   = ovf_now;
          state_d = ST_FILL;
          if (s_last) begin
            state_d   = ST_DRAIN;
            s_ready_d = 1'b0;
            err_len_d = (rcv != npins_eff) | ovf_now;
            if (npins_eff != '0) begin
              m_valid_d = 1'b1;
              m_pin_d   = PIN_W'(1);
              m_net_d   = rd_net_byp;
              m_last_d  = (npins_eff == PIN_W'(1));
            end
          end
        end
      end
      default: begin
        if (!m_valid_q || (m_ready && m_last_q)) begin
          state_d   = ST_IDLE;
          s_ready_d = 1'b1;
          m_valid_d = 1'b0;
          m_pin_d   = '0;
          m_last_d  = 1'b0;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          buf_clr   = 1'b1;
        end else if (m_ready) begin
          m_pin_d  = rd_pin;
          m_net_d  = rd_net;
          m_last_d = (rd_pin == npins_tab[kind_q]);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      kind_q    <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      m_pin_q   <= '0;
      m_net_q   <= '0;
      m_last_q  <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_pin_q   <= m_pin_d;
      m_net_q   <= m_net_d;
      m_last_q  <= m_last_d;
      err_len_q <= err_len_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_pin   = m_pin_q;
  assign m_net   = m_net_q;
  assign m_last  = m_last_q;
  assign err_len = err_len_q;

endmodule

// File: tb/tb_pinmap_term_to_pin.sv
// Directed bench for pinmap_term_to_pin; the PINMAP_PROG_EN scenario is built only with that macro.
module tb_pinmap_term_to_pin;
  import pinmap_pkg::*;

  localparam int NET_W    = 16;
  localparam int MAX_PINS = 8;
  localparam int KIND_W   = 2;
  localparam int PIN_W    = $clog2(MAX_PINS+1);
  localparam int TERM_W   = $clog2(MAX_PINS);

  logic              clk = 0, rst = 1;
  logic              s_valid = 0, s_ready, s_last = 0;
  logic [NET_W-1:0]  s_net = '0;
  logic [KIND_W-1:0] s_kind = '0;
  logic              m_valid, m_ready = 0, m_last, err_len, busy;
  logic [PIN_W-1:0]  m_pin;
  logic [NET_W-1:0]  m_net;
`ifdef PINMAP_PROG_EN
  logic              cfg_we = 0, cfg_n_we = 0;
  logic [KIND_W-1:0] cfg_kind = '0;
  logic [PIN_W-1:0]  cfg_idx = '0;
  logic [TERM_W-1:0] cfg_term = '0;
`endif

  pinmap_term_to_pin #(.NET_W(NET_W), .MAX_PINS(MAX_PINS), .KIND_W(KIND_W)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_net(s_net), .s_kind(s_kind), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_pin(m_pin), .m_net(m_net), .m_last(m_last),
    .err_len(err_len),
`ifdef PINMAP_PROG_EN
    .cfg_we(cfg_we), .cfg_kind(cfg_kind), .cfg_idx(cfg_idx), .cfg_term(cfg_term), .cfg_n_we(cfg_n_we),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, err_cnt = 0;
  always @(negedge clk) if (err_len === 1'b1) err_cnt++;

  logic [NET_W-1:0] beats [16];
  int               got_pin [16];
  logic [NET_W-1:0] got_net [16];
  logic             got_last [16];
  int               n_got, n_stall;
  int               stall_pin_obs [8];
  logic [NET_W-1:0] stall_net_obs [8];
  logic             timeout, post_sready, post_busy, first_valid;

  // Called on a negedge; leaves on the negedge after the closing beat was taken.
  task automatic send(input logic [KIND_W-1:0] kind, input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = 1; s_kind = kind; s_net = beats[i]; s_last = (i == n-1);
      @(negedge clk);
    end
    s_valid = 0; s_last = 0;
    first_valid = m_valid;
  endtask

  // Collects output beats; holds m_ready low for stall_n cycles while pin stall_pin is shown.
  task automatic drain(input int stall_pin, input int stall_n);
    int  cyc = 0;
    bit  done = 0;
    n_got = 0; n_stall = 0; timeout = 0;
    while (!done && cyc < 100) begin
      if (m_valid === 1'b1) begin
        if (int'(m_pin) == stall_pin && n_stall < stall_n) begin
          m_ready = 0;
          stall_pin_obs[n_stall] = int'(m_pin);
          stall_net_obs[n_stall] = m_net;
          n_stall++;
        end else begin
          m_ready = 1;
          got_pin[n_got] = int'(m_pin); got_net[n_got] = m_net; got_last[n_got] = m_last;
          n_got++;
          if (m_last === 1'b1) done = 1;
        end
      end else m_ready = 0;
      @(negedge clk); cyc++;
    end
    m_ready = 0;
    timeout = !done;
    post_sready = s_ready;
    post_busy = busy;
  endtask

  task automatic test_reset();
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    n_cmp++; if (m_pin !== '0) begin n_bad++; $display("FAIL reset_m_pin got %0d want 0", m_pin); end
    n_cmp++; if (m_net !== '0) begin n_bad++; $display("FAIL reset_m_net got %0h want 0", m_net); end
    n_cmp++; if (m_last !== 1'b0) begin n_bad++; $display("FAIL reset_m_last got %b want 0", m_last); end
    n_cmp++; if (err_len !== 1'b0) begin n_bad++; $display("FAIL reset_err_len got %b want 0", err_len); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_2n2222();
    logic [NET_W-1:0] exp [3] = '{16'd11, 16'd12, 16'd10};
    err_cnt = 0;
    beats[0] = 10; beats[1] = 11; beats[2] = 12;
    send(KIND_2N2222, 3);
    n_cmp++; if (first_valid !== 1'b1) begin n_bad++; $display("FAIL t2222_latency m_valid got %b want 1", first_valid); end
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL t2222_drain_s_ready got %b want 0", s_ready); end
    drain(0, 0);
    n_cmp++; if (n_got !== 3 || timeout) begin n_bad++; $display("FAIL t2222_count got %0d want 3 (timeout=%b)", n_got, timeout); end
    for (int i = 0; i < 3 && i < n_got; i++) begin
      n_cmp++;
      if (got_pin[i] !== i+1 || got_net[i] !== exp[i] || got_last[i] !== (i == 2)) begin
        n_bad++; $display("FAIL t2222_beat%0d got (%0d,%0d,%b) want (%0d,%0d,%b)",
                          i, got_pin[i], got_net[i], got_last[i], i+1, exp[i], i == 2);
      end
    end
    n_cmp++; if (err_cnt !== 0) begin n_bad++; $display("FAIL t2222_err_len pulses got %0d want 0", err_cnt); end
    n_cmp++; if (post_sready !== 1'b1 || post_busy !== 1'b0) begin
      n_bad++; $display("FAIL t2222_return s_ready/busy got %b/%b want 1/0", post_sready, post_busy); end
  endtask

  task automatic test_backpressure();
    err_cnt = 0;
    beats[0] = 5; beats[1] = 6; beats[2] = 7; beats[3] = 8;
    send(KIND_BC547, 4);
    drain(2, 3);
    n_cmp++; if (n_stall !== 3) begin n_bad++; $display("FAIL bp_stall_cycles got %0d want 3", n_stall); end
    for (int i = 0; i < n_stall; i++) begin
      n_cmp++;
      if (stall_pin_obs[i] !== 2 || stall_net_obs[i] !== 16'd6) begin
        n_bad++; $display("FAIL bp_hold%0d got (%0d,%0d) want (2,6)", i, stall_pin_obs[i], stall_net_obs[i]);
      end
    end
    n_cmp++; if (n_got !== 4 || timeout) begin n_bad++; $display("FAIL bp_count got %0d want 4", n_got); end
    for (int i = 0; i < 4 && i < n_got; i++) begin
      n_cmp++;
      if (got_pin[i] !== i+1 || got_net[i] !== NET_W'(5+i) || got_last[i] !== (i == 3)) begin
        n_bad++; $display("FAIL bp_beat%0d got (%0d,%0d,%b) want (%0d,%0d,%b)",
                          i, got_pin[i], got_net[i], got_last[i], i+1, 5+i, i == 3);
      end
    end
    n_cmp++; if (err_cnt !== 0) begin n_bad++; $display("FAIL bp_err_len pulses got %0d want 0", err_cnt); end
  endtask

  task automatic test_short();
    logic [NET_W-1:0] exp [3] = '{16'd20, 16'd21, 16'hFFFF};
    err_cnt = 0;
    beats[0] = 20; beats[1] = 21;
    send(KIND_2N3053, 2);
    drain(0, 0);
    n_cmp++; if (err_cnt !== 1) begin n_bad++; $display("FAIL short_err_len pulses got %0d want 1", err_cnt); end
    n_cmp++; if (n_got !== 3 || timeout) begin n_bad++; $display("FAIL short_count got %0d want 3", n_got); end
    for (int i = 0; i < 3 && i < n_got; i++) begin
      n_cmp++;
      if (got_pin[i] !== i+1 || got_net[i] !== exp[i] || got_last[i] !== (i == 2)) begin
        n_bad++; $display("FAIL short_beat%0d got (%0d,%0h,%b) want (%0d,%0h,%b)",
                          i, got_pin[i], got_net[i], got_last[i], i+1, exp[i], i == 2);
      end
    end
  endtask

  task automatic test_overflow();
    err_cnt = 0;
    for (int i = 0; i < 10; i++) beats[i] = NET_W'(100 + i);
    send(KIND_BC547, 10);
    drain(0, 0);
    n_cmp++; if (err_cnt !== 1) begin n_bad++; $display("FAIL ovf_err_len pulses got %0d want 1", err_cnt); end
    n_cmp++; if (n_got !== 4 || timeout) begin n_bad++; $display("FAIL ovf_count got %0d want 4", n_got); end
    for (int i = 0; i < 4 && i < n_got; i++) begin
      n_cmp++;
      if (got_pin[i] !== i+1 || got_net[i] !== NET_W'(100+i) || got_last[i] !== (i == 3)) begin
        n_bad++; $display("FAIL ovf_beat%0d got (%0d,%0d,%b) want (%0d,%0d,%b)",
                          i, got_pin[i], got_net[i], got_last[i], i+1, 100+i, i == 3);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [NET_W-1:0] exp [3] = '{16'd51, 16'd52, 16'd50};
    beats[0] = 30; beats[1] = 31; beats[2] = 32;
    send(KIND_2N2222, 3);
    m_ready = 1;
    @(negedge clk);
    m_ready = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_m_valid got %b want 0", m_valid); end
    n_cmp++; if (busy !== 1'b0 || s_ready !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_state busy/s_ready got %b/%b want 0/1", busy, s_ready); end
    beats[0] = 50; beats[1] = 51; beats[2] = 52;
    send(KIND_2N2222, 3);
    drain(0, 0);
    n_cmp++; if (n_got !== 3 || timeout) begin n_bad++; $display("FAIL rstmid_count got %0d want 3", n_got); end
    for (int i = 0; i < 3 && i < n_got; i++) begin
      n_cmp++;
      if (got_pin[i] !== i+1 || got_net[i] !== exp[i] || got_last[i] !== (i == 2)) begin
        n_bad++; $display("FAIL rstmid_beat%0d got (%0d,%0d,%b) want (%0d,%0d,%b)",
                          i, got_pin[i], got_net[i], got_last[i], i+1, exp[i], i == 2);
      end
    end
  endtask

`ifdef PINMAP_PROG_EN
  task automatic test_prog();
    for (int i = 0; i < 3; i++) begin
      cfg_we = 1; cfg_kind = 1; cfg_idx = PIN_W'(i+1); cfg_term = TERM_W'(2-i);
      @(negedge clk);
    end
    cfg_we = 0;
    for (int dev = 0; dev < 2; dev++) begin
      beats[0] = 1; beats[1] = 2; beats[2] = 3;
      send(KIND_2N2905, 3);
      if (dev == 0) begin
        cfg_we = 1; cfg_kind = 1; cfg_idx = 1; cfg_term = 0;
        @(negedge clk);
        cfg_we = 0;
      end
      drain(0, 0);
      n_cmp++; if (n_got !== 3 || timeout) begin n_bad++; $display("FAIL prog%0d_count got %0d want 3", dev, n_got); end
      for (int i = 0; i < 3 && i < n_got; i++) begin
        n_cmp++;
        if (got_pin[i] !== i+1 || got_net[i] !== NET_W'(3-i)) begin
          n_bad++; $display("FAIL prog%0d_beat%0d got (%0d,%0d) want (%0d,%0d)",
                            dev, i, got_pin[i], got_net[i], i+1, 3-i);
        end
      end
    end
  endtask
`endif

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst = 0;
    @(negedge clk);
    test_2n2222();
    test_backpressure();
    test_short();
    test_overflow();
    test_reset_mid();
`ifdef PINMAP_PROG_EN
    test_prog();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
